// File: rtl/stage_mem1.sv
// M1 pipeline register plus single-outstanding data-memory requester; outputs are registered one cycle after capture.
// Holds while stall_m1 or busy_m1 (REQ until dmem_gnt or TIMEOUT wait cycles); flush_m1 kills the stage and any open request.
module stage_mem1 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        start,
    input  logic        stall_m1,
    input  logic        flush_m1,
    input  logic        valid_e,
    input  logic [1:0]  res_sel_e,
    input  logic [31:0] aluresult_e,
    input  logic [31:0] mulresult_e,
    input  logic [31:0] divresult_e,
    input  logic [31:0] pcplus4_e,
    input  logic [31:0] storedata_e,
    input  logic [4:0]  rd_e,
    input  logic        regwrite_e,
    input  logic [1:0]  memaccess_e,
    input  logic [2:0]  funct3_e,
    input  logic        trap_e,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_err,
    output logic [31:0] result_m1,
    output logic [4:0]  rd_m1,
    output logic        regwrite_m1,
    output logic        valid_m1,
    output logic        busy_m1,
    output logic        misalign_m1,
    output logic        dmemfault_m1,
    output logic [31:0] tval_m1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [31:0] storedata_q, storedata_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwrite_q, regwrite_d;
    logic [1:0]  memaccess_q, memaccess_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        trap_q, trap_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic [31:0] sel_result;
    logic        capture;
    logic        new_req;
    logic        fault_set;
    logic        in_req;
    logic [3:0]  be_raw;
    logic [31:0] wdata_rep;
    logic        f3_sign_unused;

    // funct3[2] only selects sign/zero extension on the load-return path downstream.
    assign f3_sign_unused = funct3_q[2];

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'd0:    m = 1'b0;
            2'd1:    m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

    always_comb begin
        sel_result = aluresult_e;
        case (res_sel_e)
            2'd0: sel_result = aluresult_e;
            2'd1: sel_result = mulresult_e;
            2'd2: sel_result = divresult_e;
            2'd3: sel_result = pcplus4_e;
            default: sel_result = aluresult_e;
        endcase
    end

    assign in_req  = (state_q == REQ);
    assign busy_m1 = in_req & ~dmem_gnt;
    assign capture = valid_e & ~stall_m1 & ~flush_m1 & ~busy_m1;
    assign new_req = capture & ((memaccess_e == 2'd1) | (memaccess_e == 2'd2))
                   & ~misaligned(funct3_e, sel_result[1:0]) & ~trap_e;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fault_set = 1'b0;
        case (state_q)
            REQ: begin
                if (flush_m1) begin
                    // A grant landing with the flush is taken and thrown away.
                    state_d = IDLE;
                end else if (dmem_gnt) begin
                    fault_set = dmem_err;
                    cnt_d     = 8'd0;
                    state_d   = new_req ? REQ : DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_set = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (flush_m1) begin
                    state_d = IDLE;
                end else if (stall_m1) begin
                    state_d = state_q;
                end else if (new_req) begin
                    state_d = REQ;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        result_d    = result_q;
        storedata_d = storedata_q;
        rd_d        = rd_q;
        regwrite_d  = regwrite_q;
        memaccess_d = memaccess_q;
        funct3_d    = funct3_q;
        trap_d      = trap_q;
        valid_d     = valid_q;
        fault_d     = fault_q | fault_set;
        if (flush_m1) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            rd_d        = 5'd0;
            memaccess_d = 2'd0;
            trap_d      = 1'b0;
            fault_d     = 1'b0;
        end else if (!(stall_m1 || busy_m1)) begin
            if (capture) begin
                result_d    = sel_result;
                storedata_d = storedata_e;
                rd_d        = rd_e;
                regwrite_d  = regwrite_e;
                memaccess_d = memaccess_e;
                funct3_d    = funct3_e;
                trap_d      = trap_e;
                valid_d     = 1'b1;
                fault_d     = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            result_q    <= 32'd0;
            storedata_q <= 32'd0;
            rd_q        <= 5'd0;
            regwrite_q  <= 1'b0;
            memaccess_q <= 2'd0;
            funct3_q    <= 3'd0;
            trap_q      <= 1'b0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            storedata_q <= storedata_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            memaccess_q <= memaccess_d;
            funct3_q    <= funct3_d;
            trap_q      <= trap_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        be_raw    = 4'b1111;
        wdata_rep = storedata_q;
        case (funct3_q[1:0])
            2'd0: begin
                be_raw    = 4'b0001 << result_q[1:0];
                wdata_rep = {4{storedata_q[7:0]}};
            end
            2'd1: begin
                be_raw    = 4'b0011 << {result_q[1], 1'b0};
                wdata_rep = {2{storedata_q[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_rep = storedata_q;
            end
        endcase
    end

    assign dmem_req     = in_req;
    assign dmem_we      = in_req & (memaccess_q == 2'd2);
    assign dmem_addr    = result_q;
    assign dmem_be      = in_req ? be_raw : 4'b0000;
    assign dmem_wdata   = wdata_rep;

    assign result_m1    = result_q;
    assign rd_m1        = rd_q;
    assign valid_m1     = valid_q;
    assign misalign_m1  = valid_q & ((memaccess_q == 2'd1) | (memaccess_q == 2'd2))
                        & misaligned(funct3_q, result_q[1:0]);
    assign dmemfault_m1 = valid_q & fault_q;
    assign regwrite_m1  = valid_q & regwrite_q & ~misalign_m1 & ~dmemfault_m1 & ~trap_q;
    assign tval_m1      = (misalign_m1 | dmemfault_m1) ? result_q : 32'd0;

endmodule

// File: tb/tb_stage_mem1.sv
// Directed bench for stage_mem1: transaction-level reference model compared every cycle, plus literal spot checks.
module tb_stage_mem1;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        start;
    logic        stall_m1, flush_m1, valid_e;
    logic [1:0]  res_sel_e;
    logic [31:0] aluresult_e, mulresult_e, divresult_e, pcplus4_e, storedata_e;
    logic [4:0]  rd_e;
    logic        regwrite_e;
    logic [1:0]  memaccess_e;
    logic [2:0]  funct3_e;
    logic        trap_e;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_err;
    logic [31:0] result_m1;
    logic [4:0]  rd_m1;
    logic        regwrite_m1, valid_m1, busy_m1, misalign_m1, dmemfault_m1;
    logic [31:0] tval_m1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    stage_mem1 #(.TIMEOUT(TO)) dut (
        .clk(clk), .start(start), .stall_m1(stall_m1), .flush_m1(flush_m1),
        .valid_e(valid_e), .res_sel_e(res_sel_e), .aluresult_e(aluresult_e),
        .mulresult_e(mulresult_e), .divresult_e(divresult_e), .pcplus4_e(pcplus4_e),
        .storedata_e(storedata_e), .rd_e(rd_e), .regwrite_e(regwrite_e),
        .memaccess_e(memaccess_e), .funct3_e(funct3_e), .trap_e(trap_e),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_err(dmem_err), .result_m1(result_m1), .rd_m1(rd_m1),
        .regwrite_m1(regwrite_m1), .valid_m1(valid_m1), .busy_m1(busy_m1),
        .misalign_m1(misalign_m1), .dmemfault_m1(dmemfault_m1), .tval_m1(tval_m1)
    );

    always #5 clk = ~clk;

    // Reference: which instruction sits in M1 and whether its memory access is still outstanding.
    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        trap;
        logic        fault;
        logic        pend;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [1:0]  mem;
        logic [2:0]  f3;
        logic [7:0]  waited;
    } mdl_t;

    mdl_t m;

    function automatic logic f_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'd0) return 1'b0;
        if (f3[1:0] == 2'd1) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'd0) return 4'b0001 << a[1:0];
        if (f3[1:0] == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3[1:0] == 2'd1) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic mdl_t model_next(input mdl_t c);
        mdl_t n;
        logic busy_now, cap, pend_n, fault_n, memop, mis;
        logic [7:0] waited_n;
        logic [31:0] v;
        n = c;
        busy_now = c.pend && !dmem_gnt;
        cap      = valid_e && !stall_m1 && !flush_m1 && !busy_now;
        pend_n   = c.pend;
        fault_n  = c.fault;
        waited_n = c.waited;
        if (c.pend) begin
            if (dmem_gnt) begin
                pend_n  = 1'b0;
                fault_n = c.fault || dmem_err;
            end else if (c.waited + 8'd1 == 8'(TO)) begin
                pend_n  = 1'b0;
                fault_n = 1'b1;
            end else begin
                waited_n = c.waited + 8'd1;
            end
        end
        if (flush_m1) begin
            n.valid = 1'b0; n.rw = 1'b0; n.rd = 5'd0; n.trap = 1'b0; n.mem = 2'd0;
            n.fault = 1'b0; n.pend = 1'b0; n.waited = 8'd0;
        end else if (cap) begin
            case (res_sel_e)
                2'd0: v = aluresult_e;
                2'd1: v = mulresult_e;
                2'd2: v = divresult_e;
                default: v = pcplus4_e;
            endcase
            memop    = (memaccess_e == 2'd1) || (memaccess_e == 2'd2);
            mis      = f_mis(funct3_e, v);
            n.valid  = 1'b1; n.res = v; n.rd = rd_e; n.rw = regwrite_e; n.mem = memaccess_e;
            n.f3     = funct3_e; n.sd = storedata_e; n.trap = trap_e; n.fault = 1'b0;
            n.pend   = memop && !mis && !trap_e;
            n.waited = 8'd0;
        end else begin
            if (!(stall_m1 || busy_now)) n.valid = 1'b0;
            n.pend = pend_n; n.fault = fault_n; n.waited = waited_n;
        end
        return n;
    endfunction

    always @(posedge clk or negedge start) begin
        if (!start) m <= '0;
        else        m <= model_next(m);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic e_memop, e_mis, e_flt;
        if (chk_en) begin
            e_memop = (m.mem == 2'd1) || (m.mem == 2'd2);
            e_mis   = m.valid && e_memop && f_mis(m.f3, m.res);
            e_flt   = m.valid && m.fault;
            chk("cmp_req",      32'(dmem_req),     32'(m.pend));
            chk("cmp_we",       32'(dmem_we),      32'(m.pend && m.mem == 2'd2));
            chk("cmp_busy",     32'(busy_m1),      32'(m.pend && !dmem_gnt));
            chk("cmp_addr",     dmem_addr,         m.res);
            chk("cmp_be",       32'(dmem_be),      32'(m.pend ? f_be(m.f3, m.res) : 4'b0000));
            chk("cmp_wdata",    dmem_wdata,        f_wdata(m.f3, m.sd));
            chk("cmp_result",   result_m1,         m.res);
            chk("cmp_rd",       32'(rd_m1),        32'(m.rd));
            chk("cmp_valid",    32'(valid_m1),     32'(m.valid));
            chk("cmp_misalign", 32'(misalign_m1),  32'(e_mis));
            chk("cmp_fault",    32'(dmemfault_m1), 32'(e_flt));
            chk("cmp_regwrite", 32'(regwrite_m1),  32'(m.valid && m.rw && !e_mis && !e_flt && !m.trap));
            chk("cmp_tval",     tval_m1,           (e_mis || e_flt) ? m.res : 32'd0);
        end
    end

    task automatic idle_in();
        valid_e = 1'b0; res_sel_e = 2'd0;
        aluresult_e = 32'd0; mulresult_e = 32'd0; divresult_e = 32'd0; pcplus4_e = 32'd0;
        storedata_e = 32'd0; rd_e = 5'd0; regwrite_e = 1'b0; memaccess_e = 2'd0;
        funct3_e = 3'd0; trap_e = 1'b0; stall_m1 = 1'b0; flush_m1 = 1'b0;
        dmem_gnt = 1'b0; dmem_err = 1'b0;
    endtask

    task automatic op(input logic [1:0] sel, input logic [31:0] v, input logic [31:0] sd,
                      input logic [4:0] rd, input logic rw, input logic [1:0] mem,
                      input logic [2:0] f3, input logic trap);
        valid_e     = 1'b1;
        res_sel_e   = sel;
        aluresult_e = (sel == 2'd0) ? v : v ^ 32'h1111_0000;
        mulresult_e = (sel == 2'd1) ? v : v ^ 32'h2222_0000;
        divresult_e = (sel == 2'd2) ? v : v ^ 32'h4444_0000;
        pcplus4_e   = (sel == 2'd3) ? v : v ^ 32'h8888_0000;
        storedata_e = sd; rd_e = rd; regwrite_e = rw; memaccess_e = mem;
        funct3_e = f3; trap_e = trap;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rq, bz;
        start = 1'b1;
        idle_in();
        #1 start = 1'b0;
        #2;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_busy", 32'(busy_m1), 32'd0);
        chk("rst_valid", 32'(valid_m1), 32'd0);
        chk("rst_regwrite", 32'(regwrite_m1), 32'd0);
        chk("rst_faults", 32'({misalign_m1, dmemfault_m1}), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        #9 start = 1'b1;
        chk_en = 1'b1;
        cyc();

        // ALU result through M1
        op(2'd0, 32'h1234, 32'd0, 5'd5, 1'b1, 2'd0, 3'd2, 1'b0);
        cyc(); idle_in();
        @(negedge clk);
        chk("alu_result", result_m1, 32'h1234);
        chk("alu_rd", 32'(rd_m1), 32'd5);
        chk("alu_valid", 32'(valid_m1), 32'd1);
        chk("alu_req", 32'(dmem_req), 32'd0);
        chk("alu_regwrite", 32'(regwrite_m1), 32'd1);

        // Other result sources
        op(2'd1, 32'hCAFE_F00D, 32'd0, 5'd7, 1'b1, 2'd0, 3'd2, 1'b0);
        cyc(); idle_in(); @(negedge clk);
        chk("mul_result", result_m1, 32'hCAFE_F00D);
        op(2'd2, 32'h0000_0042, 32'd0, 5'd8, 1'b1, 2'd0, 3'd2, 1'b0);
        cyc(); idle_in(); @(negedge clk);
        chk("div_result", result_m1, 32'h0000_0042);
        op(2'd3, 32'h0000_1008, 32'd0, 5'd1, 1'b1, 2'd0, 3'd2, 1'b0);
        cyc(); idle_in(); @(negedge clk);
        chk("pc4_result", result_m1, 32'h0000_1008);

        // Trapped load: no request, no writeback
        op(2'd0, 32'h0000_0100, 32'd0, 5'd2, 1'b1, 2'd1, 3'd2, 1'b1);
        cyc(); idle_in(); @(negedge clk);
        chk("trap_req", 32'(dmem_req), 32'd0);
        chk("trap_regwrite", 32'(regwrite_m1), 32'd0);

        // Stall holds M1 even with a new instruction offered
        op(2'd0, 32'h77, 32'd0, 5'd2, 1'b1, 2'd0, 3'd2, 1'b0);
        cyc();
        op(2'd0, 32'h88, 32'd0, 5'd6, 1'b1, 2'd0, 3'd2, 1'b0);
        stall_m1 = 1'b1;
        cyc(); @(negedge clk);
        chk("stall_hold", result_m1, 32'h77);
        stall_m1 = 1'b0;
        cyc(); idle_in(); @(negedge clk);
        chk("stall_release", result_m1, 32'h88);

        // SW, grant in third request cycle
        op(2'd0, 32'h1000, 32'hAABB_CCDD, 5'd0, 1'b0, 2'd2, 3'd2, 1'b0);
        cyc(); idle_in();
        rq = 0; bz = 0;
        for (int i = 0; i < 6; i++) begin
            dmem_gnt = (i == 2);
            @(negedge clk);
            if (i == 0) begin
                chk("sw_be", 32'(dmem_be), 32'hF);
                chk("sw_wdata", dmem_wdata, 32'hAABB_CCDD);
                chk("sw_we", 32'(dmem_we), 32'd1);
            end
            rq += int'(dmem_req);
            bz += int'(busy_m1);
            cyc();
        end
        dmem_gnt = 1'b0;
        chk("sw_req_cycles", 32'(rq), 32'd3);
        chk("sw_busy_cycles", 32'(bz), 32'd2);

        // Misaligned SH
        op(2'd0, 32'h1003, 32'h1111, 5'd0, 1'b0, 2'd2, 3'd1, 1'b0);
        cyc(); idle_in(); @(negedge clk);
        chk("sh_mis", 32'(misalign_m1), 32'd1);
        chk("sh_tval", tval_m1, 32'h1003);
        rq = 0;
        for (int i = 0; i < 3; i++) begin
            rq += int'(dmem_req);
            cyc(); @(negedge clk);
        end
        chk("sh_no_req", 32'(rq), 32'd0);

        // SB lane replication
        op(2'd0, 32'h2002, 32'h0000_005A, 5'd0, 1'b0, 2'd2, 3'd0, 1'b0);
        cyc(); idle_in(); dmem_gnt = 1'b1; @(negedge clk);
        chk("sb_be", 32'(dmem_be), 32'h4);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        cyc(); dmem_gnt = 1'b0;

        // SH aligned upper half
        op(2'd0, 32'h2002, 32'h1234_BEEF, 5'd0, 1'b0, 2'd2, 3'd1, 1'b0);
        cyc(); idle_in(); dmem_gnt = 1'b1; @(negedge clk);
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        cyc(); dmem_gnt = 1'b0;

        // LBU top byte
        op(2'd0, 32'h2003, 32'd0, 5'd3, 1'b1, 2'd1, 3'd4, 1'b0);
        cyc(); idle_in(); dmem_gnt = 1'b1; @(negedge clk);
        chk("lbu_be", 32'(dmem_be), 32'h8);
        chk("lbu_we", 32'(dmem_we), 32'd0);
        cyc(); dmem_gnt = 1'b0;

        // LHU then LW captured in the grant cycle
        op(2'd0, 32'h3002, 32'd0, 5'd10, 1'b1, 2'd1, 3'd5, 1'b0);
        cyc();
        op(2'd0, 32'h3004, 32'd0, 5'd11, 1'b1, 2'd1, 3'd2, 1'b0);
        dmem_gnt = 1'b1;
        cyc(); idle_in(); @(negedge clk);
        chk("b2b_addr", dmem_addr, 32'h3004);
        chk("b2b_req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        cyc(); dmem_gnt = 1'b0;

        // Grant with error, stage stalled so the fault is visible
        op(2'd0, 32'h3000, 32'd0, 5'd9, 1'b1, 2'd1, 3'd1, 1'b0);
        cyc(); idle_in();
        dmem_gnt = 1'b1; dmem_err = 1'b1; stall_m1 = 1'b1;
        cyc(); dmem_gnt = 1'b0; dmem_err = 1'b0; @(negedge clk);
        chk("err_fault", 32'(dmemfault_m1), 32'd1);
        chk("err_tval", tval_m1, 32'h3000);
        chk("err_regwrite", 32'(regwrite_m1), 32'd0);
        stall_m1 = 1'b0;
        cyc();

        // LW timeout, TIMEOUT=4
        op(2'd0, 32'h4000, 32'd0, 5'd3, 1'b1, 2'd1, 3'd2, 1'b0);
        cyc(); idle_in();
        rq = 0; bz = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rq += int'(dmem_req);
            bz += int'(busy_m1);
            cyc();
        end
        @(negedge clk);
        chk("to_req_cycles", 32'(rq), 32'd4);
        chk("to_busy_cycles", 32'(bz), 32'd4);
        chk("to_fault", 32'(dmemfault_m1), 32'd1);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_busy_drop", 32'(busy_m1), 32'd0);
        chk("to_tval", tval_m1, 32'h4000);
        cyc();

        // Flush during REQ
        op(2'd0, 32'h5000, 32'h1122_3344, 5'd0, 1'b0, 2'd2, 3'd2, 1'b0);
        cyc(); idle_in(); @(negedge clk);
        chk("fl_req_before", 32'(dmem_req), 32'd1);
        cyc(); flush_m1 = 1'b1;
        cyc(); flush_m1 = 1'b0; @(negedge clk);
        chk("fl_req_after", 32'(dmem_req), 32'd0);
        chk("fl_valid", 32'(valid_m1), 32'd0);
        cyc();

        // Flush coincident with grant
        op(2'd0, 32'h5004, 32'd0, 5'd12, 1'b1, 2'd1, 3'd2, 1'b0);
        cyc(); idle_in(); flush_m1 = 1'b1; dmem_gnt = 1'b1; dmem_err = 1'b1;
        cyc(); idle_in(); @(negedge clk);
        chk("flg_req", 32'(dmem_req), 32'd0);
        chk("flg_fault", 32'(dmemfault_m1), 32'd0);
        cyc();

        // Reset in the middle of a request
        op(2'd0, 32'h6000, 32'd0, 5'd4, 1'b1, 2'd1, 3'd2, 1'b0);
        cyc(); idle_in(); @(negedge clk);
        #2 start = 1'b0;
        #1;
        chk("mr_req", 32'(dmem_req), 32'd0);
        chk("mr_busy", 32'(busy_m1), 32'd0);
        chk("mr_valid", 32'(valid_m1), 32'd0);
        chk("mr_addr", dmem_addr, 32'd0);
        chk("mr_rd", 32'(rd_m1), 32'd0);
        @(posedge clk);
        #3 start = 1'b1;
        rq = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rq += int'(dmem_req);
        end
        chk("mr_no_reissue", 32'(rq), 32'd0);

        cyc(); cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage_mem1.md
STAGE_MEM1 -- requirements
Module: stage_mem1

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of cycles without dmem_gnt before a fault is raised (range 1..255).
REQ-002 SHALL have port clk  in  1  clock; every flop updates on posedge.
REQ-003 SHALL have port start  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports stall_m1, flush_m1  in  1 each  hazard-unit hold and kill for the M1 register.
REQ-005 SHALL have port valid_e  in  1  EX holds a live instruction whose result is ready this cycle.
REQ-006 SHALL have port res_sel_e  in  2  result select: 0 ALU, 1 MUL, 2 DIV, 3 PC+4.
REQ-007 SHALL have ports aluresult_e, mulresult_e, divresult_e, pcplus4_e, storedata_e  in  32 each.
REQ-008 SHALL have ports rd_e  in  5, regwrite_e  in  1, memaccess_e  in  2 (0 none, 1 load, 2 store), funct3_e  in  3 (size: 0 B, 1 H, 2 W, 4 BU, 5 HU), trap_e  in  1 (upstream trap pending).
REQ-009 SHALL have ports dmem_req  out  1, dmem_we  out  1, dmem_addr  out  32, dmem_wdata  out  32, dmem_be  out  4, dmem_gnt  in  1, dmem_err  in  1.
REQ-010 SHALL have ports result_m1  out  32, rd_m1  out  5, regwrite_m1  out  1, valid_m1  out  1, busy_m1  out  1 (stall request to hazard unit).
REQ-011 SHALL have ports misalign_m1  out  1, dmemfault_m1  out  1, tval_m1  out  32 (faulting address).

Function
REQ-012 SHALL capture on posedge when valid_e & !stall_m1 & !flush_m1 & !busy_m1: result = selected source per res_sel_e, plus rd, regwrite, memaccess, funct3, storedata, trap_e; valid_m1 <= 1.
REQ-013 SHALL, on posedge with flush_m1, clear valid_m1, regwrite_m1, rd_m1 and fault flags; flush takes priority over stall and capture.
REQ-014 SHALL hold all registers when stall_m1 or busy_m1 is high and flush_m1 is low; if neither capture, stall nor flush applies, valid_m1 <= 0 (bubble).
REQ-015 SHALL drive dmem_addr = result_m1, as registered (1 cycle after capture).
REQ-016 SHALL flag misalign_m1 for H/HU with addr[0]=1, or W with addr[1:0]!=0; B/BU never misalign.
REQ-017 SHALL generate dmem_be: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111; dmem_wdata replicates byte/half across lanes.
REQ-018 SHALL implement FSM IDLE/REQ/DONE; capture of a mem op with no misalign and no trap_e -> REQ, else IDLE.
REQ-019 SHALL drive dmem_req=1 and dmem_we=(store) only in REQ; busy_m1 = REQ & !dmem_gnt.
REQ-020 SHALL on dmem_gnt in REQ go to DONE (no reissue while resident); dmem_err with gnt sets dmemfault_m1.
REQ-021 SHALL, in DONE or IDLE, go to REQ on a new mem-op capture, else stay/return IDLE on bubble.
REQ-022 SHALL count 8-bit wait cycles in REQ, clear on entry; count == TIMEOUT without gnt -> dmemfault_m1=1, state DONE, dmem_req drops.
REQ-023 SHALL, on flush_m1 in REQ without same-cycle gnt, abort to IDLE; dmem_req low next cycle; gnt coincident with flush is consumed and discarded.
REQ-024 SHALL set tval_m1 = dmem_addr when misalign_m1 or dmemfault_m1, else 0; regwrite_m1 forced 0 on any fault or trap.

Reset
REQ-025 SHALL, while start=0, asynchronously force state IDLE, counter 0, all outputs 0 (dmem_req, busy_m1, valid_m1, regwrite_m1, faults, buses).
REQ-026 SHALL abort an in-flight REQ on reset mid-operation with no request reissued after release.

Verification
REQ-027 ALU add, res_sel 0, aluresult 0x1234 rd 5 -> next cycle result_m1=0x1234, rd_m1=5, valid_m1=1, dmem_req=0.
REQ-028 SW addr 0x1000 data 0xAABBCCDD, gnt after 3 cycles -> dmem_req 3 cycles, be=1111, busy_m1 high 2 cycles, DONE.
REQ-029 SH addr 0x1003 -> misalign_m1=1, tval_m1=0x1003, dmem_req never asserted.
REQ-030 SB addr 0x2002 data 0x5A -> be=0100, wdata=0x5A5A5A5A.
REQ-031 LW, gnt never, TIMEOUT=4 -> dmemfault_m1 after 4 REQ cycles, dmem_req drops, busy_m1=0.
REQ-032 flush_m1 during REQ -> dmem_req 0 next cycle, valid_m1=0; reset low mid-REQ -> all outputs 0 immediately.
